// File: rtl/rib_if.sv
// RIB request/response bundle. The master modport drives the request and the ready.
// The slave modport drives the grant and the response.
interface rib_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] addr;
    logic          wrcs;
    logic [3:0]    mask;
    logic [DW-1:0] wdata;
    logic          req;
    logic          gnt;
    logic          rsp;
    logic [DW-1:0] rdata;
    logic          rdy;

    modport master (
        output addr, wrcs, mask, wdata, req, rdy,
        input  gnt, rsp, rdata
    );

    modport slave (
        input  addr, wrcs, mask, wdata, req, rdy,
        output gnt, rsp, rdata
    );
endinterface

// File: rtl/rib_timer_arbiter.sv
// Round-robin two-master arbiter in front of the RIB timer slave. It allows one outstanding
// transaction, buffers the response for a stalled owner, and completes with an error word on a timeout.
module rib_timer_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    rib_if.slave  m0,
    rib_if.slave  m1,
    rib_if.master s,
    output logic timeout
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        state_reg, state_next;
    logic          prio_reg, prio_next;
    logic          owner_reg, owner_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] rbuf_reg, rbuf_next;
    logic          timeout_reg, timeout_next;

    logic          sel;
    logic          owner_rdy;
    logic          s_req;
    logic          s_rdy;
    logic [1:0]    gnt_v;
    logic [1:0]    rsp_v;
    logic [DW-1:0] rdata_v [2];

    // A lone requester wins outright; under contention prio decides.
    assign sel       = m1.req & (~m0.req | prio_reg);
    assign owner_rdy = owner_reg ? m1.rdy : m0.rdy;

    assign s.addr  = sel ? m1.addr  : m0.addr;
    assign s.wrcs  = sel ? m1.wrcs  : m0.wrcs;
    assign s.mask  = sel ? m1.mask  : m0.mask;
    assign s.wdata = sel ? m1.wdata : m0.wdata;
    assign s.req   = s_req;
    assign s.rdy   = s_rdy;

    assign m0.gnt   = gnt_v[0];
    assign m1.gnt   = gnt_v[1];
    assign m0.rsp   = rsp_v[0];
    assign m1.rsp   = rsp_v[1];
    assign m0.rdata = rdata_v[0];
    assign m1.rdata = rdata_v[1];
    assign timeout  = timeout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            prio_reg    <= 1'b0;
            owner_reg   <= 1'b0;
            cnt_reg     <= '0;
            rbuf_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            prio_reg    <= prio_next;
            owner_reg   <= owner_next;
            cnt_reg     <= cnt_next;
            rbuf_reg    <= rbuf_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        prio_next    = prio_reg;
        owner_next   = owner_reg;
        cnt_next     = cnt_reg;
        rbuf_next    = rbuf_reg;
        timeout_next = 1'b0;
        s_req        = 1'b0;
        s_rdy        = 1'b0;
        gnt_v        = 2'b00;
        rsp_v        = 2'b00;
        rdata_v[0]   = '0;
        rdata_v[1]   = '0;

        case (state_reg)
            IDLE: begin
                s_req = m0.req | m1.req;
                if (s_req) begin
                    gnt_v[sel] = s.gnt;
                end
                if (s_req && s.gnt) begin
                    state_next = WAIT;
                    owner_next = sel;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                rsp_v[owner_reg]   = s.rsp;
                rdata_v[owner_reg] = s.rsp ? s.rdata : '0;
                s_rdy              = owner_rdy;
                // A response arriving on the expiry cycle takes precedence over the timeout.
                if (s.rsp) begin
                    if (owner_rdy) begin
                        state_next = IDLE;
                        prio_next  = ~owner_reg;
                    end else begin
                        rbuf_next  = s.rdata;
                        state_next = HOLD;
                    end
                end else if ((TIMEOUT != 0) && (cnt_reg == CW'(TIMEOUT - 1))) begin
                    rbuf_next    = DW'(32'hDEAD_BEEF);
                    timeout_next = 1'b1;
                    state_next   = HOLD;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                rsp_v[owner_reg]   = 1'b1;
                rdata_v[owner_reg] = rbuf_reg;
                if (owner_rdy) begin
                    state_next = IDLE;
                    prio_next  = ~owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rib_timer_arbiter.sv
// Bench for rib_timer_arbiter: directed scenarios followed by randomized traffic. Every cycle is checked
// against a transaction-level model of the arbitration, buffering and timeout rules.
module tb_rib_timer_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic timeout;
    always #5 clk = ~clk;

    rib_if #(.AW(AW), .DW(DW)) m0 ();
    rib_if #(.AW(AW), .DW(DW)) m1 ();
    rib_if #(.AW(AW), .DW(DW)) s ();

    rib_timer_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s), .timeout(timeout)
    );

    // stimulus
    logic        req_t [2];
    logic        wrcs_t [2];
    logic [3:0]  mask_t [2];
    logic [31:0] addr_t [2];
    logic [31:0] wdata_t [2];
    logic        rdy_t [2];
    logic        gnt_last [2];
    logic        s_gnt_t, s_rsp_t;
    logic [31:0] s_rdata_t;

    // reference model: phase 0=idle, 1=slave busy, 2=response parked
    int          ph, prio, owner, waited;
    logic [31:0] buf_q;
    logic        tpulse;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        ph = 0; prio = 0; owner = 0; waited = 0; buf_q = 32'h0; tpulse = 1'b0;
    endtask

    task automatic apply();
        m0.req = req_t[0]; m0.wrcs = wrcs_t[0]; m0.mask = mask_t[0];
        m0.addr = addr_t[0]; m0.wdata = wdata_t[0]; m0.rdy = rdy_t[0];
        m1.req = req_t[1]; m1.wrcs = wrcs_t[1]; m1.mask = mask_t[1];
        m1.addr = addr_t[1]; m1.wdata = wdata_t[1]; m1.rdy = rdy_t[1];
        s.gnt = s_gnt_t; s.rsp = s_rsp_t; s.rdata = s_rdata_t;
    endtask

    // one clock: predict, compare at negedge, advance the model at posedge
    task automatic cycle();
        int          sel;
        logic        sreq, erdy;
        logic [1:0]  eg, er;
        logic [31:0] ed [2];
        apply();
        if (rst) reset_model();
        sreq = (ph == 0) && (req_t[0] || req_t[1]);
        sel  = (req_t[0] && req_t[1]) ? prio : (req_t[1] ? 1 : 0);
        eg = 2'b00; er = 2'b00; ed[0] = 32'h0; ed[1] = 32'h0; erdy = 1'b0;
        if (sreq && s_gnt_t) eg[sel] = 1'b1;
        if (ph == 1) begin
            er[owner] = s_rsp_t;
            if (s_rsp_t) ed[owner] = s_rdata_t;
            erdy = rdy_t[owner];
        end
        if (ph == 2) begin
            er[owner] = 1'b1;
            ed[owner] = buf_q;
        end
        @(negedge clk);
        chk("s_req", s.req, sreq);
        if (sreq) begin
            chk("s_addr", s.addr, addr_t[sel]);
            chk("s_fields", {s.wrcs, s.mask, s.wdata}, {wrcs_t[sel], mask_t[sel], wdata_t[sel]});
        end
        chk("m0_gnt", m0.gnt, eg[0]);
        chk("m1_gnt", m1.gnt, eg[1]);
        chk("m0_rsp", m0.rsp, er[0]);
        chk("m1_rsp", m1.rsp, er[1]);
        chk("m0_rdata", m0.rdata, ed[0]);
        chk("m1_rdata", m1.rdata, ed[1]);
        chk("s_rdy", s.rdy, erdy);
        chk("timeout", timeout, tpulse);
        @(posedge clk);
        gnt_last[0] = eg[0];
        gnt_last[1] = eg[1];
        tpulse = 1'b0;
        if (rst) begin
            reset_model();
        end else if (ph == 0) begin
            if (sreq && s_gnt_t) begin
                ph = 1; owner = sel; waited = 0;
            end
        end else if (ph == 1) begin
            if (s_rsp_t) begin
                if (rdy_t[owner]) begin
                    ph = 0; prio = 1 - owner;
                end else begin
                    buf_q = s_rdata_t; ph = 2;
                end
            end else if (waited == TO - 1) begin
                buf_q = 32'hDEAD_BEEF; tpulse = 1'b1; ph = 2;
            end else begin
                waited++;
            end
        end else if (rdy_t[owner]) begin
            ph = 0; prio = 1 - owner;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_t[i] = 1'b1; wrcs_t[i] = w; addr_t[i] = a; wdata_t[i] = d; mask_t[i] = 4'hF;
    endtask

    task automatic all_idle();
        for (int i = 0; i < 2; i++) begin
            req_t[i] = 1'b0; wrcs_t[i] = 1'b0; mask_t[i] = 4'h0;
            addr_t[i] = 32'h0; wdata_t[i] = 32'h0; rdy_t[i] = 1'b1; gnt_last[i] = 1'b0;
        end
        s_gnt_t = 1'b0; s_rsp_t = 1'b0; s_rdata_t = 32'h0;
    endtask

    // mode 0: random rsp, 1: slave silent, 2: rsp only on the expiry cycle
    task automatic random_run(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_t[i] || gnt_last[i]) begin
                    req_t[i]   = ($urandom_range(99) < 50);
                    wrcs_t[i]  = 1'($urandom_range(1));
                    mask_t[i]  = 4'($urandom_range(15));
                    addr_t[i]  = $urandom;
                    wdata_t[i] = $urandom;
                end
                rdy_t[i] = ($urandom_range(99) < 60);
            end
            s_gnt_t   = (req_t[0] || req_t[1]) && ($urandom_range(99) < 70);
            s_rdata_t = $urandom;
            case (mode)
                0:       s_rsp_t = ($urandom_range(99) < 30);
                1:       s_rsp_t = 1'b0;
                default: s_rsp_t = (ph == 1) && (waited == TO - 1);
            endcase
            rst = ($urandom_range(399) == 0);
            cycle();
            rst = 1'b0;
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        all_idle();
        reset_model();
        cycle();
        cycle();
        rst = 1'b0;

        // m0 read of 0x4, response one cycle after grant
        set_req(0, 1'b0, 32'h4, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        req_t[0] = 1'b0; s_gnt_t = 1'b0; s_rsp_t = 1'b1; s_rdata_t = 32'h0000_0123;
        cycle();
        s_rsp_t = 1'b0;
        cycle();

        // both masters hold req: alternating grants
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 32'h20, 32'hA5);
        for (int k = 0; k < 4; k++) begin
            s_gnt_t = 1'b1; s_rsp_t = 1'b0;
            cycle();
            s_gnt_t = 1'b0; s_rsp_t = 1'b1; s_rdata_t = 32'h100 + k;
            cycle();
        end
        all_idle();

        // m1 write with a stalled response while m0 keeps asking
        set_req(1, 1'b1, 32'h8, 32'h5);
        s_gnt_t = 1'b1;
        cycle();
        req_t[1] = 1'b0; rdy_t[1] = 1'b0;
        set_req(0, 1'b0, 32'hC, 32'h0);
        s_rsp_t = 1'b1; s_rdata_t = 32'h0000_0055;
        cycle();
        s_rsp_t = 1'b0; s_rdata_t = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) cycle();
        rdy_t[1] = 1'b1;
        cycle();
        cycle();
        all_idle();

        // silent slave: timeout completion, then a fresh grant
        set_req(0, 1'b0, 32'h4, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        req_t[0] = 1'b0; s_gnt_t = 1'b0;
        for (int k = 0; k < TO + 2; k++) cycle();
        set_req(1, 1'b0, 32'h4, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        req_t[1] = 1'b0; s_gnt_t = 1'b0; s_rsp_t = 1'b1; s_rdata_t = 32'h77;
        cycle();
        all_idle();

        // response exactly on the expiry cycle
        set_req(1, 1'b0, 32'h4, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        req_t[1] = 1'b0; s_gnt_t = 1'b0;
        for (int k = 0; k < TO - 1; k++) cycle();
        s_rsp_t = 1'b1; s_rdata_t = 32'h0000_0456;
        cycle();
        s_rsp_t = 1'b0;
        cycle();

        // async reset in the middle of a transaction, then a stray late response
        set_req(1, 1'b0, 32'h4, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        req_t[1] = 1'b0; s_gnt_t = 1'b0;
        cycle();
        apply();
        rst = 1'b1;
        #1;
        chk("rst_m1_rsp", m1.rsp, 1'b0);
        chk("rst_s_rdy", s.rdy, 1'b0);
        cycle();
        rst = 1'b0;
        s_rsp_t = 1'b1; s_rdata_t = 32'hBAD0_0001;
        cycle();
        s_rsp_t = 1'b0;
        set_req(0, 1'b0, 32'h30, 32'h0);
        set_req(1, 1'b0, 32'h34, 32'h0);
        s_gnt_t = 1'b1;
        cycle();
        all_idle();
        cycle();

        // randomized traffic
        random_run(800, 0);
        random_run(300, 1);
        random_run(400, 2);
        random_run(400, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
